nf_gpio_seq: RTL and testbench

- Autonomous pattern sequencer and bus arbiter placed between the nf_router GPIO slot and the GPIO register block.
- Plays a programmed list of GPO values into the GPIO output register, with a programmable inter-write delay and optional looping.
- Shares the GPIO register bus with the CPU; the CPU always has priority.
- Configured through its own register port.

---
 rtl/nf_gpio_seq.sv | 202 ++++++++++++++++++++
 tb/tb_nf_gpio_seq.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf_gpio_seq.sv
// nf_gpio_seq: plays a programmed GPO pattern onto the shared GPIO register bus; the CPU always wins the bus.
// Define NF_GPIO_SEQ_DIR_EN to add a DIR register (offset 0x14) written once before each started run.
`ifndef NF_GPIO_WIDTH
`define NF_GPIO_WIDTH 8
`endif
`ifndef NF_GPIO_GPO
`define NF_GPIO_GPO 32'h0000_0004
`endif
`ifndef NF_GPIO_DIR
`define NF_GPIO_DIR 32'h0000_0008
`endif

module nf_gpio_seq #(
  parameter int depth  = 16,
  parameter int gpio_w = `NF_GPIO_WIDTH,
  parameter int dly_w  = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] cfg_addr,
  input  logic        cfg_we,
  input  logic [31:0] cfg_wd,
  output logic [31:0] cfg_rd,
  input  logic        cpu_sel,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic [31:0] gpio_addr,
  output logic        gpio_we,
  output logic [31:0] gpio_wd,
  input  logic [31:0] gpio_rd,
  output logic        done
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0]      LEN_MAX = (AW+1)'(depth);
  localparam logic [AW:0]      ONE_L   = (AW+1)'(1);
  localparam logic [AW-1:0]    ONE_A   = AW'(1);
  localparam logic [dly_w-1:0] ONE_D   = dly_w'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WR    = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
`ifdef NF_GPIO_SEQ_DIR_EN
  localparam logic [1:0] S_WRDIR = 2'd3;
`endif

  logic [1:0]        state;
  logic [AW-1:0]     ptr;
  logic [AW-1:0]     idx;
  logic [AW:0]       len;
  logic [dly_w-1:0]  dly;
  logic [dly_w-1:0]  cnt;
  logic              loop_r;
  logic              done_r;
  logic [gpio_w-1:0] mem [depth];
`ifdef NF_GPIO_SEQ_DIR_EN
  logic [gpio_w-1:0] dir_r;
`endif

  logic [4:0]  off;
  logic        wr_ctrl, wr_len, wr_ptr, wr_data, wr_dly;
  logic        start, abort, busy, last_entry, advance;
  logic [AW:0] len_in, len_sat;
  logic        unused_bits;

  assign off     = cfg_addr[4:0];
  assign wr_ctrl = cfg_we && (off == 5'h00);
  assign wr_len  = cfg_we && (off == 5'h04);
  assign wr_ptr  = cfg_we && (off == 5'h08);
  assign wr_data = cfg_we && (off == 5'h0C);
  assign wr_dly  = cfg_we && (off == 5'h10);
  assign start   = wr_ctrl && cfg_wd[0];
  assign abort   = wr_ctrl && cfg_wd[2];
  assign busy    = (state != S_IDLE);

  assign len_in  = cfg_wd[AW:0];
  assign len_sat = (len_in > LEN_MAX) ? LEN_MAX : len_in;

  // NEXT is not a register state: it is the decision taken on the edge that leaves WR or WAIT.
  assign last_entry = ({1'b0, idx} == (len - ONE_L));
  assign advance    = ((state == S_WR) && !cpu_sel && (dly == '0)) ||
                      ((state == S_WAIT) && (cnt == ONE_D));

  assign unused_bits = ^{cfg_addr[31:5], cfg_wd};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      ptr    <= '0;
      idx    <= '0;
      len    <= '0;
      dly    <= '0;
      cnt    <= '0;
      loop_r <= 1'b0;
      done_r <= 1'b0;
`ifdef NF_GPIO_SEQ_DIR_EN
      dir_r  <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      if (wr_ctrl) loop_r <= cfg_wd[1];
      if (wr_len)  len    <= len_sat;
      if (wr_dly)  dly    <= cfg_wd[dly_w-1:0];
      if (wr_ptr)  ptr    <= cfg_wd[AW-1:0];
      if (wr_data) ptr    <= ptr + ONE_A;
`ifdef NF_GPIO_SEQ_DIR_EN
      if (cfg_we && (off == 5'h14)) dir_r <= cfg_wd[gpio_w-1:0];
`endif

      if (abort) begin
        state <= S_IDLE;
      end else if (start && (len != '0)) begin
        idx <= '0;
`ifdef NF_GPIO_SEQ_DIR_EN
        state <= S_WRDIR;
`else
        state <= S_WR;
`endif
      end else begin
        case (state)
          S_WR: begin
            if (!cpu_sel && (dly != '0)) begin
              cnt   <= dly;
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (cnt != ONE_D) cnt <= cnt - ONE_D;
          end
`ifdef NF_GPIO_SEQ_DIR_EN
          S_WRDIR: begin
            if (!cpu_sel) state <= S_WR;
          end
`endif
          default: ;
        endcase

        if (advance) begin
          if (last_entry) begin
            idx <= '0;
            if (loop_r) begin
              state <= S_WR;
            end else begin
              state  <= S_IDLE;
              done_r <= 1'b1;
            end
          end else begin
            idx   <= idx + ONE_A;
            state <= S_WR;
          end
        end
      end
    end
  end

  // Pattern memory is deliberately left out of reset so a reset keeps the loaded pattern.
  always_ff @(posedge clk) begin
    if (wr_data) mem[ptr] <= cfg_wd[gpio_w-1:0];
  end

  always_comb begin
    gpio_addr = cpu_addr;
    gpio_we   = cpu_we;
    gpio_wd   = cpu_wd;
    if (!cpu_sel) begin
      gpio_we = 1'b0;
      if (state == S_WR) begin
        gpio_addr = `NF_GPIO_GPO;
        gpio_we   = 1'b1;
        gpio_wd   = 32'(mem[idx]);
      end
`ifdef NF_GPIO_SEQ_DIR_EN
      else if (state == S_WRDIR) begin
        gpio_addr = `NF_GPIO_DIR;
        gpio_we   = 1'b1;
        gpio_wd   = 32'(dir_r);
      end
`endif
    end
  end

  always_comb begin
    cfg_rd = '0;
    case (off)
      5'h00: cfg_rd = {16'b0, 8'(idx), 6'b0, loop_r, busy};
      5'h04: cfg_rd = 32'(len);
      5'h08: cfg_rd = 32'(ptr);
      5'h0C: cfg_rd = 32'(mem[ptr]);
      5'h10: cfg_rd = 32'(dly);
`ifdef NF_GPIO_SEQ_DIR_EN
      5'h14: cfg_rd = 32'(dir_r);
`endif
      default: cfg_rd = '0;
    endcase
  end

  assign cpu_rd = gpio_rd;
  assign done   = done_r;

endmodule

// File: tb/tb_nf_gpio_seq.sv
// Self-checking bench for nf_gpio_seq: directed scenarios plus randomized runs against a schedule model.
`ifndef NF_GPIO_WIDTH
`define NF_GPIO_WIDTH 8
`endif
`ifndef NF_GPIO_GPO
`define NF_GPIO_GPO 32'h0000_0004
`endif
`ifndef NF_GPIO_DIR
`define NF_GPIO_DIR 32'h0000_0008
`endif

module tb_nf_gpio_seq;
  localparam int DEPTH = 16;
  localparam int GW    = `NF_GPIO_WIDTH;
  localparam int NMAX  = 100;
  localparam logic [31:0] GPO   = `NF_GPIO_GPO;
  localparam logic [31:0] DIRA  = `NF_GPIO_DIR;
  localparam logic [31:0] GMASK = (GW >= 32) ? 32'hFFFF_FFFF : ((32'd1 << GW) - 32'd1);
`ifdef NF_GPIO_SEQ_DIR_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] cfg_addr, cfg_wd, cfg_rd;
  logic        cfg_we;
  logic        cpu_sel, cpu_we;
  logic [31:0] cpu_addr, cpu_wd, cpu_rd;
  logic [31:0] gpio_addr, gpio_wd, gpio_rd;
  logic        gpio_we, done;

  nf_gpio_seq dut (
    .clk(clk), .resetn(resetn),
    .cfg_addr(cfg_addr), .cfg_we(cfg_we), .cfg_wd(cfg_wd), .cfg_rd(cfg_rd),
    .cpu_sel(cpu_sel), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd),
    .gpio_addr(gpio_addr), .gpio_we(gpio_we), .gpio_wd(gpio_wd), .gpio_rd(gpio_rd),
    .done(done)
  );

  always #5 clk = ~clk;

  // Reference model of the register file and pattern memory
  logic [31:0] mem_m [DEPTH];
  int          ptr_m, len_m, dly_m;
  bit          loop_m;
  logic [31:0] dir_m;

  // Expected per-cycle bus activity after a start, built from the run rules
  bit          sel_a   [NMAX];
  bit          exp_we  [NMAX];
  logic [31:0] exp_addr[NMAX];
  logic [31:0] exp_wd  [NMAX];
  bit          exp_done[NMAX];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    int v;
    cfg_addr = {27'b0, a};
    cfg_wd   = d;
    cfg_we   = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    case (a)
      5'h00: loop_m = d[1];
      5'h04: begin v = int'(d % (2 * DEPTH)); len_m = (v > DEPTH) ? DEPTH : v; end
      5'h08: ptr_m = int'(d % DEPTH);
      5'h0C: begin mem_m[ptr_m] = d & GMASK; ptr_m = (ptr_m + 1) % DEPTH; end
      5'h10: dly_m = int'(d & 32'hFFFF);
      5'h14: if (DIR_EN) dir_m = d & GMASK;
      default: ;
    endcase
  endtask

  task automatic cfg_read(input logic [4:0] a, output logic [31:0] v);
    cfg_addr = {27'b0, a};
    #1 v = cfg_rd;
  endtask

  task automatic model_reset();
    ptr_m = 0; len_m = 0; dly_m = 0; loop_m = 0; dir_m = 0;
  endtask

  task automatic plan_run(input int ln, input int dl, input bit lp, input int nrun);
    int t, k;
    for (int i = 0; i < NMAX; i++) begin
      exp_we[i] = 0; exp_addr[i] = 0; exp_wd[i] = 0; exp_done[i] = 0;
    end
    t = 1;
    if (DIR_EN) begin
      while (t <= nrun && sel_a[t]) t++;
      if (t <= nrun) begin exp_we[t] = 1; exp_addr[t] = DIRA; exp_wd[t] = dir_m; end
      t++;
    end
    k = 0;
    while (t <= nrun) begin
      while (t <= nrun && sel_a[t]) t++;
      if (t > nrun) break;
      exp_we[t] = 1; exp_addr[t] = GPO; exp_wd[t] = mem_m[k];
      k++;
      if (k == ln) begin
        k = 0;
        if (!lp) begin
          if (t + dl + 1 < NMAX) exp_done[t + dl + 1] = 1;
          break;
        end
      end
      t += dl + 1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [4:0]  ra [4];
    ra = '{5'h00, 5'h04, 5'h08, 5'h10};
    cpu_sel = 0; cpu_we = 1;
    #2;
    n_checks++;
    if ({gpio_we, gpio_addr, gpio_wd, done} !== {1'b0, cpu_addr, cpu_wd, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_idle_mux: got we=%b addr=%h wd=%h done=%b, want we=0 addr=%h wd=%h done=0",
               gpio_we, gpio_addr, gpio_wd, done, cpu_addr, cpu_wd);
    end
    cpu_sel = 1;
    #1;
    n_checks++;
    if ({gpio_we, gpio_wd, cpu_rd} !== {1'b1, cpu_wd, gpio_rd}) begin
      n_fail++;
      $display("FAIL reset_cpu_pass: got we=%b wd=%h rd=%h, want we=1 wd=%h rd=%h",
               gpio_we, gpio_wd, cpu_rd, cpu_wd, gpio_rd);
    end
    cpu_sel = 0; cpu_we = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    for (int i = 0; i < 4; i++) begin
      cfg_read(ra[i], v);
      n_checks++;
      if (v !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_reg_%0h: got %h, want 00000000", ra[i], v);
      end
    end
  endtask

  task automatic test_basic();
    int          wc [3];
    logic [31:0] wv [3];
    logic [65:0] got, want;
    int          ndone;
    logic [31:0] v;
    wc = '{1, 4, 7};
    wv = '{32'h1, 32'h2, 32'h4};
    ndone = 0;
    cfg_write(5'h08, 0);
    cfg_write(5'h0C, 1); cfg_write(5'h0C, 2); cfg_write(5'h0C, 4);
    cfg_write(5'h04, 3); cfg_write(5'h10, 2);
    cfg_write(5'h00, 1);
    for (int t = 1; t <= 12; t++) begin
      cpu_sel = 0; cpu_we = 1;
      @(negedge clk);
      want = {1'b0, cpu_addr, cpu_wd, 1'b0};
      for (int i = 0; i < 3; i++) if (t == wc[i]) want = {1'b1, GPO, wv[i], 1'b0};
      if (t == 10) want[0] = 1'b1;
      got = {gpio_we, gpio_addr, gpio_wd, done};
      ndone += int'(done);
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL basic cyc%0d: got we=%b addr=%h wd=%h done=%b, want we=%b addr=%h wd=%h done=%b",
                 t, got[65], got[64:33], got[32:1], got[0], want[65], want[64:33], want[32:1], want[0]);
      end
      @(posedge clk); #1;
    end
    cfg_read(5'h00, v);
    n_checks++;
    if (v[0] !== 1'b0 || ndone != 1) begin
      n_fail++;
      $display("FAIL basic_end: got busy=%b done_pulses=%0d, want busy=0 done_pulses=1", v[0], ndone);
    end
  endtask

  task automatic test_contention();
    int          wc [3];
    logic [31:0] wv [3];
    logic [65:0] got, want;
    wc = '{2, 5, 8};
    wv = '{32'h1, 32'h2, 32'h4};
    cfg_write(5'h00, 1);
    for (int t = 1; t <= 12; t++) begin
      cpu_sel  = (t == 1);
      cpu_we   = 1;
      cpu_addr = (t == 1) ? GPO : 32'h40;
      cpu_wd   = (t == 1) ? 32'hAA : 32'h99;
      @(negedge clk);
      want = {1'b0, cpu_addr, cpu_wd, 1'b0};
      if (t == 1) want = {1'b1, GPO, 32'hAA, 1'b0};
      for (int i = 0; i < 3; i++) if (t == wc[i]) want = {1'b1, GPO, wv[i], 1'b0};
      if (t == 11) want[0] = 1'b1;
      got = {gpio_we, gpio_addr, gpio_wd, done};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL contention cyc%0d: got we=%b addr=%h wd=%h done=%b, want we=%b addr=%h wd=%h done=%b",
                 t, got[65], got[64:33], got[32:1], got[0], want[65], want[64:33], want[32:1], want[0]);
      end
      @(posedge clk); #1;
    end
    cpu_sel = 0; cpu_addr = 32'h40; cpu_wd = 32'h99;
  endtask

  task automatic test_loop_abort();
    logic [65:0] got, want;
    logic [31:0] v;
    cfg_write(5'h04, 2); cfg_write(5'h10, 0);
    cfg_write(5'h00, 3);
    for (int t = 1; t <= 8; t++) begin
      cpu_sel = 0; cpu_we = 1;
      if (t == 5) begin cfg_addr = 0; cfg_wd = 4; cfg_we = 1; end
      else cfg_we = 0;
      @(negedge clk);
      want = {1'b0, cpu_addr, cpu_wd, 1'b0};
      if (t <= 5) want = {1'b1, GPO, ((t % 2) == 1) ? 32'h1 : 32'h2, 1'b0};
      got = {gpio_we, gpio_addr, gpio_wd, done};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL loop_abort cyc%0d: got we=%b addr=%h wd=%h done=%b, want we=%b addr=%h wd=%h done=%b",
                 t, got[65], got[64:33], got[32:1], got[0], want[65], want[64:33], want[32:1], want[0]);
      end
      @(posedge clk); #1;
    end
    cfg_we = 0; loop_m = 0;
    cfg_read(5'h00, v);
    n_checks++;
    if (v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_abort_busy: got %b, want 0", v[0]);
    end
  endtask

  task automatic test_edge_cfg();
    logic [31:0] v;
    logic [31:0] wv [17];
    cfg_write(5'h04, 0);
    cfg_write(5'h00, 1);
    for (int t = 1; t <= 6; t++) begin
      cpu_sel = 0; cpu_we = 1;
      @(negedge clk);
      n_checks++;
      if ({gpio_we, done} !== 2'b00) begin
        n_fail++;
        $display("FAIL len0_start cyc%0d: got we=%b done=%b, want we=0 done=0", t, gpio_we, done);
      end
      @(posedge clk); #1;
    end
    cfg_write(5'h04, 20);
    cfg_read(5'h04, v);
    n_checks++;
    if (v !== 32'd16) begin n_fail++; $display("FAIL len_saturate: got %0d, want 16", v); end
    cfg_write(5'h08, 0);
    for (int i = 0; i < 17; i++) begin
      wv[i] = $urandom;
      cfg_write(5'h0C, wv[i]);
    end
    cfg_read(5'h08, v);
    n_checks++;
    if (v !== 32'd1) begin n_fail++; $display("FAIL ptr_wrap: got %0d, want 1", v); end
    cfg_write(5'h08, 0);
    cfg_read(5'h0C, v);
    n_checks++;
    if (v !== (wv[16] & GMASK)) begin
      n_fail++;
      $display("FAIL mem0_overwrite: got %h, want %h", v, wv[16] & GMASK);
    end
    cfg_write(5'h08, 1);
    cfg_read(5'h0C, v);
    n_checks++;
    if (v !== (wv[1] & GMASK)) begin n_fail++; $display("FAIL mem1_kept: got %h, want %h", v, wv[1] & GMASK); end
    cfg_write(5'h00, 2);
    cfg_read(5'h00, v);
    n_checks++;
    if (v !== 32'h2) begin n_fail++; $display("FAIL ctrl_loop_rd: got %h, want 00000002", v); end
    cfg_read(5'h18, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd: got %h, want 00000000", v); end
`ifndef NF_GPIO_SEQ_DIR_EN
    cfg_write(5'h14, 32'hFF);
    cfg_read(5'h14, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL dir_absent_rd: got %h, want 00000000", v); end
`endif
  endtask

  task automatic test_random();
    int          ln, dl;
    bit          lp;
    logic [65:0] got, want;
    logic [31:0] v;
    for (int it = 0; it < 8; it++) begin
      cfg_write(5'h08, 0);
      for (int i = 0; i < DEPTH; i++) cfg_write(5'h0C, $urandom);
      ln = $urandom_range(1, 6);
      dl = $urandom_range(0, 3);
      lp = bit'($urandom_range(0, 1));
      cfg_write(5'h04, ln);
      cfg_write(5'h10, dl);
      for (int t = 0; t < NMAX; t++) sel_a[t] = (t < 40) && ($urandom_range(0, 3) == 0);
      plan_run(len_m, dly_m, lp, 80);
      cfg_write(5'h00, lp ? 32'd3 : 32'd1);
      for (int t = 1; t <= 80; t++) begin
        cpu_sel  = sel_a[t];
        cpu_we   = 1'($urandom_range(0, 1));
        cpu_addr = $urandom;
        cpu_wd   = $urandom;
        @(negedge clk);
        if (sel_a[t])      want = {cpu_we, cpu_addr, cpu_wd, exp_done[t]};
        else if (exp_we[t]) want = {1'b1, exp_addr[t], exp_wd[t], exp_done[t]};
        else               want = {1'b0, cpu_addr, cpu_wd, exp_done[t]};
        got = {gpio_we, gpio_addr, gpio_wd, done};
        n_checks++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL random it%0d cyc%0d len=%0d dly=%0d loop=%0d: got we=%b addr=%h wd=%h done=%b, want we=%b addr=%h wd=%h done=%b",
                   it, t, ln, dl, lp, got[65], got[64:33], got[32:1], got[0],
                   want[65], want[64:33], want[32:1], want[0]);
        end
        @(posedge clk); #1;
      end
      cpu_sel = 0; cpu_we = 0; cpu_addr = 32'h40; cpu_wd = 32'h99;
      if (lp) cfg_write(5'h00, 4);
      cfg_read(5'h00, v);
      n_checks++;
      if (v[0] !== 1'b0) begin n_fail++; $display("FAIL random_end it%0d: busy got %b, want 0", it, v[0]); end
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] v;
    cfg_write(5'h04, 2); cfg_write(5'h10, 5);
    cfg_write(5'h00, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    cfg_read(5'h00, v);
    n_checks++;
    if (v[0] !== 1'b1) begin n_fail++; $display("FAIL midrun_busy: got %b, want 1", v[0]); end
    resetn = 0; cpu_sel = 0; cpu_we = 1;
    model_reset();
    @(negedge clk);
    n_checks++;
    if ({gpio_we, gpio_addr, done} !== {1'b0, cpu_addr, 1'b0}) begin
      n_fail++;
      $display("FAIL midrun_reset_mux: got we=%b addr=%h done=%b, want we=0 addr=%h done=0",
               gpio_we, gpio_addr, done, cpu_addr);
    end
    @(posedge clk); #1;
    cfg_read(5'h00, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL midrun_ctrl: got %h, want 00000000", v); end
    cpu_sel = 1;
    @(negedge clk);
    n_checks++;
    if ({gpio_we, gpio_wd} !== {1'b1, cpu_wd}) begin
      n_fail++;
      $display("FAIL midrun_pass: got we=%b wd=%h, want we=1 wd=%h", gpio_we, gpio_wd, cpu_wd);
    end
    @(posedge clk); #1;
    resetn = 1; cpu_sel = 0; cpu_we = 0;
    cfg_read(5'h04, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL midrun_len: got %h, want 00000000", v); end
    cfg_read(5'h0C, v);
    n_checks++;
    if (v !== mem_m[0]) begin n_fail++; $display("FAIL mem_survives_reset: got %h, want %h", v, mem_m[0]); end
  endtask

`ifdef NF_GPIO_SEQ_DIR_EN
  task automatic test_dir();
    logic [65:0] got, want;
    logic [31:0] v;
    cfg_write(5'h14, 32'hF0);
    cfg_read(5'h14, v);
    n_checks++;
    if (v !== 32'hF0) begin n_fail++; $display("FAIL dir_rd: got %h, want 000000f0", v); end
    cfg_write(5'h08, 0); cfg_write(5'h0C, 1); cfg_write(5'h0C, 2);
    cfg_write(5'h04, 2); cfg_write(5'h10, 0);
    cfg_write(5'h00, 3);
    for (int t = 1; t <= 8; t++) begin
      cpu_sel = 0; cpu_we = 1;
      if (t == 6) begin cfg_addr = 0; cfg_wd = 4; cfg_we = 1; end
      else cfg_we = 0;
      @(negedge clk);
      want = {1'b0, cpu_addr, cpu_wd, 1'b0};
      if (t == 1) want = {1'b1, DIRA, 32'hF0, 1'b0};
      else if (t <= 6) want = {1'b1, GPO, ((t % 2) == 0) ? 32'h1 : 32'h2, 1'b0};
      got = {gpio_we, gpio_addr, gpio_wd, done};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL dir_run cyc%0d: got we=%b addr=%h wd=%h done=%b, want we=%b addr=%h wd=%h done=%b",
                 t, got[65], got[64:33], got[32:1], got[0], want[65], want[64:33], want[32:1], want[0]);
      end
      @(posedge clk); #1;
    end
    cfg_we = 0; loop_m = 0;
  endtask
`endif

  initial begin
    resetn = 0;
    cfg_addr = 0; cfg_we = 0; cfg_wd = 0;
    cpu_sel = 0; cpu_we = 0; cpu_addr = 32'h40; cpu_wd = 32'h99;
    gpio_rd = 32'h1234_5678;
    model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
    test_reset();
`ifndef NF_GPIO_SEQ_DIR_EN
    test_basic();
    test_contention();
    test_loop_abort();
`endif
    test_edge_cfg();
    test_random();
    test_reset_midrun();
`ifdef NF_GPIO_SEQ_DIR_EN
    test_dir();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
